// File: rtl/alu_pkg.sv
// Shared definitions for the lab ALU and its sequencer.
// Function codes, FSM state encoding and the OR-detect default.
package alu_pkg;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_ORD = 3'd2;
  localparam logic [2:0] FN_LOG = 3'd3;
  localparam logic [2:0] FN_CAT = 3'd4;
  localparam logic [2:0] FN_SHL = 3'd5;
  localparam logic [2:0] FN_SHR = 3'd6;
  localparam logic [2:0] FN_MUL = 3'd7;

  localparam logic [7:0] ORRED_DEF = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 8-function 4-bit ALU with an 8-bit result.
// Shared by the sequencer and the standalone lab tops.
module alu_core
  import alu_pkg::*;
#(
  parameter logic [7:0] ORRED_VAL = ORRED_DEF
) (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] func,
  output logic [7:0] y
);

  logic [7:0] a8;
  logic [7:0] b8;

  assign a8 = {4'b0, a};
  assign b8 = {4'b0, b};

  always_comb begin
    y = '0;
    unique case (func)
      FN_ADD: y = a8 + b8;
      FN_SUB: y = {4'b0, a - b};
      FN_ORD: y = (|{a, b}) ? ORRED_VAL : 8'h00;
      FN_LOG: y = {a ^ b, a | b};
      FN_CAT: y = {a, b};
      // shifts of 8 or more drain the byte to zero
      FN_SHL: y = b8 << a;
      FN_SHR: y = b8 >> a;
      FN_MUL: y = a8 * b8;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer: applies one ALU function Count times,
// feeding the result's low nibble back in as operand B.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int         CNT_W     = 4,
  parameter logic [7:0] ORRED_VAL = ORRED_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Func,
  input  logic [3:0]       A,
  input  logic [CNT_W-1:0] Count,
  input  logic             Clear,
  output logic             Busy,
  output logic             Done,
  output logic [7:0]       ALUOut,
  output logic [CNT_W-1:0] Iter
);

  state_t     state;
  logic [2:0] func_q;
  logic [3:0] a_q;
  logic [7:0] alu_y;

  alu_core #(
    .ORRED_VAL(ORRED_VAL)
  ) u_alu (
    .a   (a_q),
    .b   (ALUOut[3:0]),
    .func(func_q),
    .y   (alu_y)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= ST_IDLE;
      ALUOut <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Iter   <= '0;
      func_q <= '0;
      a_q    <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (Clear)
            ALUOut <= '0;
          if (Start) begin
            func_q <= Func;
            a_q    <= A;
            Iter   <= Count;
            if (Count != '0) begin
              state <= ST_RUN;
              Busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              Done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          ALUOut <= alu_y;
          Iter   <= Iter - CNT_W'(1);
          // last iteration hands straight to the Done pulse
          if (Iter == CNT_W'(1)) begin
            state <= ST_DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed scenarios plus random runs
// checked against a transaction-level model of the sequencer.
module tb_alu_seq_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [2:0] Func;
  logic [3:0] A;
  logic [3:0] Count;
  logic       Clear;
  logic       Busy;
  logic       Done;
  logic [7:0] ALUOut;
  logic [3:0] Iter;

  int n_chk  = 0;
  int n_pass = 0;
  int res    = 0;

  always #5 Clock = ~Clock;

  alu_seq_ctrl dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Func  (Func),
    .A     (A),
    .Count (Count),
    .Clear (Clear),
    .Busy  (Busy),
    .Done  (Done),
    .ALUOut(ALUOut),
    .Iter  (Iter)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic int alu_ref(int f, int a, int b);
    case (f)
      0: return a + b;
      1: return (a - b + 16) % 16;
      2: return ((a | b) != 0) ? 'h0F : 0;
      3: return ((a ^ b) * 16) + (a | b);
      4: return a * 16 + b;
      5: return (a >= 8) ? 0 : ((b << a) % 256);
      6: return b >> a;
      default: return (a * b) % 256;
    endcase
  endfunction

  // Called just after a negedge with the DUT idle.
  task automatic run_op(input bit clr, input int f,
                        input int a, input int n,
                        input bit noise);
    Start = 1'b1;
    Clear = clr;
    Func  = 3'(f);
    A     = 4'(a);
    Count = 4'(n);
    @(negedge Clock);
    Start = 1'b0;
    Clear = 1'b0;
    if (clr) res = 0;
    for (int k = 0; k < n; k++) begin
      chk("busy", Busy, 1);
      chk("done_run", Done, 0);
      chk("iter", Iter, n - k);
      chk("aluout_run", ALUOut, res);
      if (noise) begin
        Start = 1'($urandom);
        Clear = 1'($urandom);
        Func  = 3'($urandom);
        A     = 4'($urandom);
        Count = 4'($urandom);
      end
      res = alu_ref(f, a, res % 16);
      @(negedge Clock);
    end
    Start = 1'b0;
    Clear = 1'b0;
    chk("done", Done, 1);
    chk("busy_done", Busy, 0);
    chk("iter_done", Iter, 0);
    chk("aluout", ALUOut, res);
    @(negedge Clock);
    chk("done_clr", Done, 0);
    chk("busy_idle", Busy, 0);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Clear = 1'b0;
    Func  = '0;
    A     = '0;
    Count = '0;
    repeat (2) @(negedge Clock);
    chk("rst_alu", ALUOut, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_iter", Iter, 0);
    Reset = 1'b0;
    @(negedge Clock);

    run_op(1, 0, 3, 4, 0);
    chk("t1_final", ALUOut, 8'h0C);

    run_op(1, 0, 2, 1, 0);
    chk("t2_add", ALUOut, 8'h02);
    run_op(0, 7, 3, 2, 0);
    chk("t2_mul", ALUOut, 8'h12);

    run_op(0, 0, 5, 0, 0);
    chk("t4_cnt0", ALUOut, 8'h12);

    run_op(1, 2, 0, 1, 0);
    chk("t3_ord0", ALUOut, 8'h00);
    run_op(0, 2, 1, 1, 0);
    chk("t3_ord1", ALUOut, 8'h0F);

    run_op(1, 0, 1, 5, 1);
    chk("t5_noise", ALUOut, 8'h05);

    Start = 1'b1;
    Func  = 3'd0;
    A     = 4'd3;
    Count = 4'd6;
    @(negedge Clock);
    Start = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("mid_rst_alu", ALUOut, 0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_done", Done, 0);
    chk("mid_rst_iter", Iter, 0);
    Reset = 1'b0;
    res = 0;
    @(negedge Clock);
    chk("post_rst_done", Done, 0);

    run_op(1, 1, 0, 1, 0);
    chk("t6_sub0", ALUOut, 8'h00);
    run_op(0, 0, 1, 1, 0);
    run_op(0, 1, 0, 1, 0);
    chk("t6_sub1", ALUOut, 8'h0F);
    run_op(0, 5, 9, 1, 0);
    chk("t6_shl9", ALUOut, 8'h00);

    for (int i = 0; i < 60; i++)
      run_op(($urandom % 4) == 0,
             $urandom % 8, $urandom % 16,
             $urandom % 6, 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
